cpu_core: RTL and testbench
===========================

# cpu_core

Single-clock 8-bit accumulator CPU (VeriRISC-style) with an internal 32×8 unified instruction/data memory. Every instruction is an 8-bit word, {opcode[7:5], address[4:0]}, and takes eight clock phases driven by an internal phase counter. The block is the top of the processor subsystem. The bench preloads its memory through hierarchy and watches `halt` to end a run.

## Interface
- No parameters. Data width is 8 bits, address width is 5 bits, memory depth is 32; all are fixed.
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst_`  in  1  reset, asynchronous, active-low.
- `halt`  out  1  high while a HLT instruction has been executed; stays high until reset.
- `load_ir`  out  1  high during the INST_LOAD and IDLE phases, while the instruction register is being loaded.
- Hierarchical names fixed for benches:
  - memory instance `mem1`, array `memory[0:31]`, byte-wide;
  - program counter `pc_addr`, 5 bits.

## Operation
- Opcodes:
  - HLT=0
  - SKZ=1, skip the next instruction if accumulator == 0
  - ADD=2, AC ← AC + M
  - AND=3, AC ← AC & M
  - XOR=4, AC ← AC ^ M
  - LDA=5, AC ← M
  - STO=6, M ← AC
  - JMP=7, PC ← addr
- M is `memory[IR[4:0]]`.
- Registers: PC (5 bits), IR (8 bits), AC (8 bits), phase (3 bits).
- `zero` = (AC == 0), combinational.
- ALU is combinational, 8-bit, with modulo-256 wrap and no carry or flags (FF+01 = 00).
- Memory read is combinational on the address. Memory write is synchronous.
- Address mux: PC during phases 0–3, IR[4:0] during phases 4–7.
- Phases, in order:
  - 0 INST_ADDR: address = PC.
  - 1 INST_FETCH: read memory.
  - 2 INST_LOAD: IR ← memory[PC] at the end of the phase; `load_ir` = 1.
  - 3 IDLE: `load_ir` = 1.
  - 4 OP_ADDR:
    - if IR opcode is HLT: set the halt flag, no PC increment, phase stays at 4 (frozen) until reset;
    - otherwise PC ← PC+1.
  - 5 OP_FETCH: operand read for ADD/AND/XOR/LDA.
  - 6 ALU_OP:
    - SKZ with zero=1: PC ← PC+1;
    - JMP: PC ← IR[4:0].
  - 7 STORE:
    - ADD/AND/XOR/LDA: AC ← ALU result;
    - STO: memory[IR[4:0]] ← AC.
  - Then return to phase 0.
- PC wraps 31 → 0.
- SKZ skipping from address 31 wraps to 0.
- Reset values: PC=0, IR=0, AC=0, phase=0, `halt`=0, `load_ir`=0. Memory is not cleared.
- Reset asserted mid-instruction aborts the instruction immediately. Any pending STO does not occur.

## Timing
- Each non-HLT instruction takes exactly 8 clk cycles.
- `halt` rises on the first edge that enters phase 4 with HLT in IR, i.e. 4 cycles after that instruction starts. `pc_addr` then equals the address of the HLT word.
- A JMP or SKZ target is fetched starting on the next phase 0. Phase 7 is inert for these two opcodes.
- STO writes on the rising edge ending phase 7. A following instruction reading that address sees the new value.
- Reset release: the first instruction fetch starts on the first rising clk edge with `rst_`=1.

## Structure
- Shared package `typedefs` holds:
  - `opcode_t` enum (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP, 3 bits, the values above);
  - `state_t` enum for the eight phases.
- Natural sub-modules:
  - `mem`, instance `mem1`: 32×8 array, combinational read, clocked write;
  - optional combinational `alu`.
- Controller, PC, IR, AC and the address mux live in the top module.

## Test plan
- Each test below starts from reset, except where stated, and memory is otherwise zero.
- LDA/STO: memory holds 0x00=LDA 1C, 0x01=STO 1A, 0x02=HLT, memory[1C]=05.
  - Required: memory[1A]=05, `halt` high 20 cycles after reset, `pc_addr`=2.
- SKZ taken: memory holds 0x00=LDA 1C, 0x01=SKZ, 0x02=JMP 00, 0x03=HLT, memory[1C]=00.
  - Required: JMP is skipped, halt with PC=3.
- SKZ not taken plus XOR: memory holds LDA 1A, XOR 1D, SKZ, HLT at 0x03, HLT at 0x04, with memory[1A]=AA and memory[1D]=00.
  - Required: AC=AA, halt at PC=3.
- JMP: memory holds 0x00=JMP 03, 0x03=LDA 1A, 0x04=HLT, memory[1A]=05.
  - Required: halt at PC=4, AC=05, addresses 1–2 never executed.
- ADD wrap and AND:
  - LDA FF, ADD 01: AC=00 and zero=1.
  - LDA AA, AND FF: AC=AA.
- Reset mid-run:
  - Assert `rst_` during phase 6 of a STO: no write, all registers 0, `halt`=0.
  - Reset while halted: `halt` clears and execution restarts at 0.

Source files
------------

// File: rtl/typedefs.sv
// Shared types for the 8-bit accumulator CPU: opcodes, phase encoding, ALU helper.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package typedefs;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 5;
  localparam int MEM_DEPTH = 32;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // Eight instruction phases; bit 2 set means the operand half of the instruction.
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  // Modulo-256 ALU, no carry or flags. Opcodes that do not load AC pass it through.
  function automatic logic [DATA_W-1:0] alu(input opcode_t op,
                                            input logic [DATA_W-1:0] ac,
                                            input logic [DATA_W-1:0] m);
    logic [DATA_W-1:0] res;
    res = ac;
    case (op)
      ADD:     res = ac + m;
      AND:     res = ac & m;
      XOR:     res = ac ^ m;
      LDA:     res = m;
      default: res = ac;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_core_mem.sv
// Unified 32x8 instruction/data memory: combinational read, clocked write, no reset.
// Latency: read 0 cycles (same cycle as address), write lands on the rising edge.
// Backpressure: none; always accepts a write when i_we is high.
// Ports: clk; i_we write enable; i_addr 5-bit address; i_wdata write byte; o_rdata read byte.
module cpu_core_mem
  import typedefs::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents are deliberately left out of reset so a program survives a CPU reset.
  logic [DATA_W-1:0] memory [0:MEM_DEPTH-1];

  assign o_rdata = memory[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      memory[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/cpu_core.sv
// 8-bit accumulator CPU top: phase controller, PC, IR, AC, address mux, memory instance.
// Latency: 8 cycles per instruction; HLT raises halt 4 cycles after its fetch starts.
// Backpressure: none; free-running, only reset or HLT stops the phase counter.
// Ports: clk clock; rst_ async active-low reset; halt sticky HLT flag; load_ir high in INST_LOAD/IDLE.
module cpu_core
  import typedefs::*;
(
  input  logic clk,
  input  logic rst_,
  output logic halt,
  output logic load_ir
);

  logic [ADDR_W-1:0] pc_addr;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_ac;
  logic              r_halt;
  state_t            r_phase;
  state_t            w_phase_nxt;

  opcode_t           w_op;
  logic [ADDR_W-1:0] w_opnd;
  logic              w_zero;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rdata;

  logic w_ir_ld;
  logic w_halt_set;
  logic w_pc_inc;
  logic w_pc_jmp;
  logic w_ac_ld;
  logic w_mem_we;

  assign w_op   = opcode_t'(r_ir[7:5]);
  assign w_opnd = r_ir[4:0];
  assign w_zero = (r_ac == '0);

  // Phases 0-3 address the instruction via PC, phases 4-7 the operand via IR.
  assign w_addr = r_phase[2] ? w_opnd : pc_addr;

  assign halt = r_halt;

  cpu_core_mem mem1 (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_addr),
    .i_wdata (r_ac),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_phase <= INST_ADDR;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    load_ir     = 1'b0;
    w_ir_ld     = 1'b0;
    w_halt_set  = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_jmp    = 1'b0;
    w_ac_ld     = 1'b0;
    w_mem_we    = 1'b0;
    case (r_phase)
      INST_ADDR:  w_phase_nxt = INST_FETCH;
      INST_FETCH: w_phase_nxt = INST_LOAD;
      INST_LOAD: begin
        load_ir     = 1'b1;
        w_ir_ld     = 1'b1;
        w_phase_nxt = IDLE;
      end
      IDLE: begin
        load_ir     = 1'b1;
        // IR is already valid here, so halt is raised on the edge entering OP_ADDR.
        w_halt_set  = (w_op == HLT);
        w_phase_nxt = OP_ADDR;
      end
      OP_ADDR: begin
        // HLT parks the controller here with PC still pointing at the HLT word.
        if (w_op != HLT) begin
          w_pc_inc    = 1'b1;
          w_phase_nxt = OP_FETCH;
        end
      end
      OP_FETCH: w_phase_nxt = ALU_OP;
      ALU_OP: begin
        w_pc_inc    = (w_op == SKZ) && w_zero;
        w_pc_jmp    = (w_op == JMP);
        w_phase_nxt = STORE;
      end
      STORE: begin
        w_ac_ld     = (w_op == ADD) || (w_op == AND) || (w_op == XOR) || (w_op == LDA);
        w_mem_we    = (w_op == STO);
        w_phase_nxt = INST_ADDR;
      end
      default: w_phase_nxt = INST_ADDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pc_addr <= '0;
      r_ir    <= '0;
      r_ac    <= '0;
      r_halt  <= 1'b0;
    end else begin
      if (w_ir_ld) begin
        r_ir <= w_rdata;
      end
      if (w_pc_jmp) begin
        pc_addr <= w_opnd;
      end else if (w_pc_inc) begin
        pc_addr <= pc_addr + 5'd1;
      end
      if (w_ac_ld) begin
        r_ac <= alu(w_op, r_ac, w_rdata);
      end
      if (w_halt_set) begin
        r_halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic halt;
  logic load_ir;

  cpu_core dut (
    .clk     (clk),
    .rst_    (rst_),
    .halt    (halt),
    .load_ir (load_ir)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] img [32];

  // Reference model state: instruction-level interpreter of the program image.
  logic [7:0] m_mem [32];
  logic [4:0] m_pc;
  logic [7:0] m_ac;
  logic       m_halted;
  int         m_steps;

  typedef struct {
    string      name;
    logic [7:0] opw;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_ac;
    logic       exp_zero;
  } alu_vec_t;

  alu_vec_t vt [8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
  endtask

  // Hold reset, preload memory, release on a falling edge so the next rising edge is cycle 1.
  task automatic start();
    rst_ = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) dut.mem1.memory[i] = img[i];
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_run(input int limit);
    logic [7:0] ir;
    logic [4:0] a;
    for (int i = 0; i < 32; i++) m_mem[i] = img[i];
    m_pc = 5'd0;
    m_ac = 8'd0;
    m_halted = 1'b0;
    m_steps = limit;
    for (int n = 0; n < limit; n++) begin
      ir = m_mem[m_pc];
      a  = ir[4:0];
      if (ir[7:5] == 3'd0) begin
        m_halted = 1'b1;
        m_steps = n;
        break;
      end
      m_pc = m_pc + 5'd1;
      case (ir[7:5])
        3'd1: if (m_ac == 8'd0) m_pc = m_pc + 5'd1;
        3'd2: m_ac = m_ac + m_mem[a];
        3'd3: m_ac = m_ac & m_mem[a];
        3'd4: m_ac = m_ac ^ m_mem[a];
        3'd5: m_ac = m_mem[a];
        3'd6: m_mem[a] = m_ac;
        default: m_pc = a;
      endcase
    end
  endtask

  function automatic int mem_diffs();
    int d;
    d = 0;
    for (int i = 0; i < 32; i++) if (dut.mem1.memory[i] !== m_mem[i]) d++;
    return d;
  endfunction

  initial begin
    // Program: LDA 1C, <op> 1D, HLT with memory[1C]=a, memory[1D]=b.
    vt[0] = '{"add_wrap",  8'h5D, 8'hFF, 8'h01, 8'h00, 1'b1};
    vt[1] = '{"and_ff",    8'h7D, 8'hAA, 8'hFF, 8'hAA, 1'b0};
    vt[2] = '{"xor_00",    8'h9D, 8'hAA, 8'h00, 8'hAA, 1'b0};
    vt[3] = '{"add_7f",    8'h5D, 8'h7F, 8'h01, 8'h80, 1'b0};
    vt[4] = '{"and_mask",  8'h7D, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vt[5] = '{"xor_ff",    8'h9D, 8'hFF, 8'h0F, 8'hF0, 1'b0};
    vt[6] = '{"lda_over",  8'hBD, 8'h12, 8'h34, 8'h34, 1'b0};
    vt[7] = '{"add_80_80", 8'h5D, 8'h80, 8'h80, 8'h00, 1'b1};

    // Reset state.
    rst_ = 1'b0;
    #1;
    chk("rst_halt", halt, 0);
    chk("rst_load_ir", load_ir, 0);
    chk("rst_pc", dut.pc_addr, 0);
    chk("rst_ir", dut.r_ir, 0);
    chk("rst_ac", dut.r_ac, 0);
    chk("rst_phase", dut.r_phase, 0);

    // LDA/STO/HLT with load_ir timing and halt timing.
    clear_img();
    img[0] = 8'hBC; img[1] = 8'hDA; img[2] = 8'h00; img[5'h1C] = 8'h05;
    start();
    cycles(1); chk("ldir_ph1", load_ir, 0);
    cycles(1); chk("ldir_ph2", load_ir, 1);
    cycles(1); chk("ldir_ph3", load_ir, 1);
    cycles(1); chk("ldir_ph4", load_ir, 0);
    cycles(15); chk("sto_halt_c19", halt, 0);
    cycles(1);
    chk("sto_halt_c20", halt, 1);
    chk("sto_pc", dut.pc_addr, 2);
    chk("sto_mem1a", dut.mem1.memory[5'h1A], 8'h05);
    chk("sto_ac", dut.r_ac, 8'h05);
    cycles(5);
    chk("halt_sticky", halt, 1);
    chk("halt_pc_frozen", dut.pc_addr, 2);
    chk("halt_phase_frozen", dut.r_phase, 4);

    // Reset while halted: flag clears, execution restarts at address 0.
    rst_ = 1'b0;
    #1;
    chk("rsth_halt", halt, 0);
    chk("rsth_pc", dut.pc_addr, 0);
    @(negedge clk);
    rst_ = 1'b1;
    cycles(5);  chk("rsth_pc_c5", dut.pc_addr, 1);
    cycles(15); chk("rsth_rehalt", halt, 1);
    chk("rsth_repc", dut.pc_addr, 2);

    // Reset during phase 6 of a STO: the write is dropped.
    clear_img();
    img[0] = 8'hBC; img[1] = 8'hDA; img[2] = 8'h00; img[5'h1C] = 8'h05;
    start();
    cycles(14);
    chk("msto_phase6", dut.r_phase, 6);
    chk("msto_ac_pre", dut.r_ac, 8'h05);
    rst_ = 1'b0;
    #1;
    chk("msto_pc", dut.pc_addr, 0);
    chk("msto_ir", dut.r_ir, 0);
    chk("msto_ac", dut.r_ac, 0);
    chk("msto_phase", dut.r_phase, 0);
    chk("msto_halt", halt, 0);
    chk("msto_load_ir", load_ir, 0);
    cycles(3);
    chk("msto_no_write", dut.mem1.memory[5'h1A], 8'h00);

    // SKZ taken: JMP 00 at address 2 is skipped.
    clear_img();
    img[0] = 8'hBC; img[1] = 8'h20; img[2] = 8'hE0; img[3] = 8'h00; img[5'h1C] = 8'h00;
    start();
    cycles(19); chk("skzt_halt_c19", halt, 0);
    cycles(1);  chk("skzt_halt", halt, 1);
    chk("skzt_pc", dut.pc_addr, 3);

    // SKZ not taken after XOR.
    clear_img();
    img[0] = 8'hBA; img[1] = 8'h9D; img[2] = 8'h20; img[3] = 8'h00; img[4] = 8'h00;
    img[5'h1A] = 8'hAA; img[5'h1D] = 8'h00;
    start();
    cycles(28);
    chk("skzn_halt", halt, 1);
    chk("skzn_pc", dut.pc_addr, 3);
    chk("skzn_ac", dut.r_ac, 8'hAA);

    // JMP over addresses 1-2 (which hold HLT).
    clear_img();
    img[0] = 8'hE3; img[3] = 8'hBA; img[4] = 8'h00; img[5'h1A] = 8'h05;
    start();
    cycles(20);
    chk("jmp_halt", halt, 1);
    chk("jmp_pc", dut.pc_addr, 4);
    chk("jmp_ac", dut.r_ac, 8'h05);

    // SKZ at address 31 wraps past 0 to 1.
    clear_img();
    img[0] = 8'hFF; img[31] = 8'h20; img[1] = 8'h00;
    start();
    cycles(20);
    chk("skzw_halt", halt, 1);
    chk("skzw_pc", dut.pc_addr, 1);

    // Table of ALU vectors.
    for (int v = 0; v < 8; v++) begin
      clear_img();
      img[0] = 8'hBC; img[1] = vt[v].opw; img[2] = 8'h00;
      img[5'h1C] = vt[v].a; img[5'h1D] = vt[v].b;
      start();
      cycles(20);
      chk($sformatf("%s_halt", vt[v].name), halt, 1);
      chk($sformatf("%s_ac", vt[v].name), dut.r_ac, vt[v].exp_ac);
      chk($sformatf("%s_zero", vt[v].name), dut.w_zero, vt[v].exp_zero);
    end

    // Random programs against the instruction-level model.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 32; i++) img[i] = 8'($urandom_range(0, 255));
      model_run(40);
      start();
      if (m_halted) begin
        cycles(8 * m_steps + 3);
        chk($sformatf("rnd%0d_halt_early", t), halt, 0);
        cycles(1);
        chk($sformatf("rnd%0d_halt", t), halt, 1);
      end else begin
        cycles(320);
        chk($sformatf("rnd%0d_nohalt", t), halt, 0);
      end
      chk($sformatf("rnd%0d_pc", t), dut.pc_addr, m_pc);
      chk($sformatf("rnd%0d_ac", t), dut.r_ac, m_ac);
      chk($sformatf("rnd%0d_mem_diffs", t), mem_diffs(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
